regfile_sb: RTL and testbench

Parametrised register file with two registered read ports, a general write port and a dedicated special-register port. It adds a per-register pending scoreboard and optional write-to-read forwarding. It sits in the decode stage of the pipeline datapath: decode reads operands and allocates destinations, and writeback retires results.

---
 rtl/regfile_sb.sv | 152 +++++++++++++++
 tb/tb_regfile_sb.sv | 129 ++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: decode-stage register file with two registered read ports,
// a general write port, a dedicated special-register write port and a
// per-register pending scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write forwarding
// to the read outputs, and hazard masking of pending bits being retired).
module regfile_sb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int SPEC_IDX = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_en,
   input  logic [ADDR_W-1:0]    rd_addr1,
   input  logic [ADDR_W-1:0]    rd_addr2,
   output logic [DATA_W-1:0]    rd_data1,
   output logic [DATA_W-1:0]    rd_data2,
   output logic [DATA_W-1:0]    rd_spec,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic                 spec_wr_en,
   input  logic [DATA_W-1:0]    spec_wr_data,
   input  logic                 alloc_en,
   input  logic [ADDR_W-1:0]    alloc_addr,
   output logic                 hazard,
   output logic [(2**ADDR_W)-1:0] pending
);

   localparam int NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] SPEC_A = ADDR_W'(SPEC_IDX);

   logic [DATA_W-1:0] r_regs [NREG];
   logic [NREG-1:0]   r_pending;
   logic [NREG-1:0]   w_set;
   logic [NREG-1:0]   w_clr;
   logic [NREG-1:0]   w_pend_nxt;
   logic [NREG-1:0]   w_hz_pend;
   logic              w_wr_gen;
   logic [DATA_W-1:0] w_src1;
   logic [DATA_W-1:0] w_src2;
   logic [DATA_W-1:0] w_src_spec;

   assign w_wr_gen = wr_en && (wr_addr != '0);

`ifdef REGFILE_BYPASS_EN
   // Value a read of address a returns this cycle, including in-flight writes;
   // the special port outranks the general port on SPEC_IDX.
   function automatic logic [DATA_W-1:0] f_fwd(
      input logic [ADDR_W-1:0] a,
      input logic [DATA_W-1:0] stored,
      input logic              we,
      input logic [ADDR_W-1:0] wa,
      input logic [DATA_W-1:0] wd,
      input logic              swe,
      input logic [DATA_W-1:0] swd
   );
      logic [DATA_W-1:0] v;
      v = stored;
      if (a == '0)
         v = '0;
      else if (swe && (a == SPEC_A))
         v = swd;
      else if (we && (a == wa))
         v = wd;
      return v;
   endfunction

   // Read sources with forwarding from the general and special write ports
   always_comb begin
      w_src1     = f_fwd(rd_addr1, r_regs[rd_addr1], wr_en, wr_addr, wr_data,
                         spec_wr_en, spec_wr_data);
      w_src2     = f_fwd(rd_addr2, r_regs[rd_addr2], wr_en, wr_addr, wr_data,
                         spec_wr_en, spec_wr_data);
      w_src_spec = f_fwd(SPEC_A, r_regs[SPEC_A], wr_en, wr_addr, wr_data,
                         spec_wr_en, spec_wr_data);
   end

   // A bit being retired this cycle does not stall, unless it is re-allocated
   assign w_hz_pend = r_pending & ~(w_clr & ~w_set);
`else
   // Read sources are the stored (pre-write) values; register 0 stays zero
   always_comb begin
      w_src1     = r_regs[rd_addr1];
      w_src2     = r_regs[rd_addr2];
      w_src_spec = r_regs[SPEC_A];
   end

   assign w_hz_pend = r_pending;
`endif

   // Scoreboard set/clear masks for this cycle
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (alloc_en && (alloc_addr != '0))
         w_set[alloc_addr] = 1'b1;
      if (w_wr_gen)
         w_clr[wr_addr] = 1'b1;
      if (spec_wr_en)
         w_clr[SPEC_A] = 1'b1;
      // set applied after clear: a newer producer stays outstanding
      w_pend_nxt = ((r_pending & ~w_clr) | w_set) & {{(NREG-1){1'b1}}, 1'b0};
   end

   // Register array update; register 0 is never written
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++)
            r_regs[i] <= '0;
      end else begin
         for (int unsigned i = 1; i < NREG; i++) begin
            if (spec_wr_en && (ADDR_W'(i) == SPEC_A))
               r_regs[i] <= spec_wr_data;
            else if (wr_en && (ADDR_W'(i) == wr_addr))
               r_regs[i] <= wr_data;
         end
      end
   end

   // Registered read ports (held while rd_en is low) and the special copy
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data1 <= '0;
         rd_data2 <= '0;
         rd_spec  <= '0;
      end else begin
         if (rd_en) begin
            rd_data1 <= w_src1;
            rd_data2 <= w_src2;
         end
         rd_spec <= w_src_spec;
      end
   end

   // Pending scoreboard register
   always_ff @(posedge clk) begin
      if (rst)
         r_pending <= '0;
      else
         r_pending <= w_pend_nxt;
   end

   assign pending = r_pending;

   // Combinational hazard on either current read address
   always_comb begin
      hazard = ((rd_addr1 != '0) && w_hz_pend[rd_addr1]) ||
               ((rd_addr2 != '0) && w_hz_pend[rd_addr2]);
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven directed vectors for regfile_sb, followed by
// hand-written sequences for forwarding, same-cycle set/clear and reset.
module tb_regfile_sb;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst, rd_en, wr_en, spec_wr_en, alloc_en;
   logic [ADDR_W-1:0] rd_addr1, rd_addr2, wr_addr, alloc_addr;
   logic [DATA_W-1:0] wr_data, spec_wr_data;
   logic [DATA_W-1:0] rd_data1, rd_data2, rd_spec;
   logic              hazard;
   logic [15:0]       pending;

   regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SPEC_IDX(15)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_spec(rd_spec),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .spec_wr_en(spec_wr_en), .spec_wr_data(spec_wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr),
      .hazard(hazard), .pending(pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rd_en;
      logic [3:0]  a1;
      logic [3:0]  a2;
      logic        we;
      logic [3:0]  wa;
      logic [15:0] wd;
      logic        swe;
      logic [15:0] swd;
      logic        al;
      logic [3:0]  aa;
      logic        chk_hz;
      logic        hz;
      logic [15:0] d1;
      logic [15:0] d2;
      logic        chk_sp;
      logic [15:0] sp;
      logic [15:0] pend;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;
   int step  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
      end
   endtask

   // One cycle: drive, check hazard before the edge, check registers after it
   task automatic cyc(input vec_t v);
      rst = v.rst; rd_en = v.rd_en; rd_addr1 = v.a1; rd_addr2 = v.a2;
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      spec_wr_en = v.swe; spec_wr_data = v.swd;
      alloc_en = v.al; alloc_addr = v.aa;
      #2;
      if (v.chk_hz) chk("hazard", {31'd0, hazard}, {31'd0, v.hz});
      @(posedge clk);
      #1;
      chk("rd_data1", {16'd0, rd_data1}, {16'd0, v.d1});
      chk("rd_data2", {16'd0, rd_data2}, {16'd0, v.d2});
      if (v.chk_sp) chk("rd_spec", {16'd0, rd_spec}, {16'd0, v.sp});
      chk("pending", {16'd0, pending}, {16'd0, v.pend});
      step++;
   endtask

   vec_t tbl [13];
   vec_t seq [14];

   initial begin
      //          rst rd a1 a2 we wa wd        swe swd       al aa  chz hz d1        d2        csp sp        pend
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,  0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000};
      tbl[1]  = '{0, 1, 3, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000};
      tbl[2]  = '{0, 0, 0, 0, 1, 5, 16'h1234, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000};
      tbl[3]  = '{0, 1, 5, 3, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,  1, 0, 16'h1234, 16'h0000, 1, 16'h0000, 16'h0000};
      tbl[4]  = '{0, 1, 0, 5, 1, 0, 16'hFFFF, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 16'h1234, 1, 16'h0000, 16'h0000};
      tbl[5]  = '{0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000};
      tbl[6]  = '{0, 0, 0, 0, 1,15, 16'hAAAA, 1, 16'h5555, 0, 0,  1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
      tbl[7]  = '{0, 1,15, 5, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,  1, 0, 16'h5555, 16'h1234, 1, 16'h5555, 16'h0000};
      tbl[8]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 7,  1, 0, 16'h5555, 16'h1234, 1, 16'h5555, 16'h0080};
      tbl[9]  = '{0, 1, 7, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,  1, 1, 16'h0000, 16'h0000, 1, 16'h5555, 16'h0080};
      tbl[10] = '{0, 0, 0, 7, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,  1, 1, 16'h0000, 16'h0000, 1, 16'h5555, 16'h0080};
      tbl[11] = '{0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0,  1, 0, 16'h0000, 16'h0000, 1, 16'h5555, 16'h0080};
      tbl[12] = '{0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 7,  1, 0, 16'h0000, 16'h0000, 1, 16'h5555, 16'h0080};

      // write retiring pending reg 7 while it is being read
      seq[0]  = '{0, 1, 7, 0, 1, 7, 16'h00FF, 0, 16'h0000, 0, 0,  1, !BYP, BYP ? 16'h00FF : 16'h0000, 16'h0000, 1, 16'h5555, 16'h0000};
      seq[1]  = '{0, 1, 7, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,  1, 0, 16'h00FF, 16'h0000, 1, 16'h5555, 16'h0000};
      // same-cycle alloc and write on reg 9: set wins
      seq[2]  = '{0, 0, 0, 0, 1, 9, 16'h0909, 0, 16'h0000, 1, 9,  1, 0, 16'h00FF, 16'h0000, 1, 16'h5555, 16'h0200};
      seq[3]  = '{0, 1, 9, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,  1, 1, 16'h0909, 16'h0000, 1, 16'h5555, 16'h0200};
      // special port retires pending SPEC_IDX and forwards to rd_spec
      seq[4]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1,15,  1, 0, 16'h0909, 16'h0000, 1, 16'h5555, 16'h8200};
      seq[5]  = '{0, 1,15, 0, 0, 0, 16'h0000, 1, 16'h1111, 0, 0,  1, !BYP, BYP ? 16'h1111 : 16'h5555, 16'h0000, 1, BYP ? 16'h1111 : 16'h5555, 16'h0200};
      seq[6]  = '{0, 1,15, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,  1, 0, 16'h1111, 16'h0000, 1, 16'h1111, 16'h0200};
      // reset mid-stream discards allocations and overrides strobes
      seq[7]  = '{0, 1, 5, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 2,  1, 0, 16'h1234, 16'h0000, 1, 16'h1111, 16'h0204};
      seq[8]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 4,  1, 0, 16'h1234, 16'h0000, 1, 16'h1111, 16'h0214};
      seq[9]  = '{1, 1, 2, 4, 1, 5, 16'hFFFF, 1, 16'h2222, 1, 3,  1, 1, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000};
      seq[10] = '{0, 1, 2, 4, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000};
      seq[11] = '{0, 1, 5,15, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000};
      // hold behaviour: rd_en low keeps outputs after new writes
      seq[12] = '{0, 1, 6, 0, 1, 6, 16'hBEEF, 0, 16'h0000, 0, 0,  1, 0, BYP ? 16'hBEEF : 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000};
      seq[13] = '{0, 0, 6, 6, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,  1, 0, BYP ? 16'hBEEF : 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000};

      for (int i = 0; i < 13; i++) cyc(tbl[i]);
      for (int i = 0; i < 14; i++) cyc(seq[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
